// File: rtl/btr_share_if.sv
// Request/response bundle between two requesters, the shared bit-reverse
// arbiter and the response consumer.
interface btr_share_if;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_op;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_op;
  logic        req1_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic        rsp_ready;

  modport master (
    output req0_valid, req0_data, req0_op, req1_valid, req1_data, req1_op, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_op, req1_valid, req1_data, req1_op, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/btr_share_arb.sv
// Round-robin share of one bit-reverse datapath between two requesters, with a
// one-deep registered response and saturating per-requester grant counters.
//
// state | meaning
// EMPTY | output register holds nothing
// FULL  | output register holds an unconsumed result
module btr_share_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  btr_share_if.slave       bus,
  output logic             busy,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state;
  logic        ptr;
  logic [15:0] rsp_data_q;
  logic        rsp_id_q;

  logic        can_accept;
  logic        win1;
  logic        gnt0;
  logic        gnt1;
  logic [15:0] sel_data;
  logic        sel_op;
  logic [15:0] rev_full;
  logic [15:0] rev_byte;
  logic [15:0] result;

  // ptr names the requester that wins when both ask in the same cycle
  always_comb begin
    can_accept = (state == EMPTY) || bus.rsp_ready;
    win1       = bus.req1_valid && (!bus.req0_valid || ptr);
    gnt0       = !rst && can_accept && bus.req0_valid && !win1;
    gnt1       = !rst && can_accept && win1;
    sel_data   = win1 ? bus.req1_data : bus.req0_data;
    sel_op     = win1 ? bus.req1_op   : bus.req0_op;
  end

  always_comb begin
    rev_full = '0;
    rev_byte = '0;
    for (int i = 0; i < 16; i++) begin
      rev_full[15-i] = sel_data[i];
    end
    for (int i = 0; i < 8; i++) begin
      rev_byte[7-i]  = sel_data[i];
      rev_byte[15-i] = sel_data[8+i];
    end
    result = sel_op ? rev_byte : rev_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      ptr        <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      gnt_cnt0   <= '0;
      gnt_cnt1   <= '0;
    end else if (gnt0 || gnt1) begin
      // a drain and a new accept on the same edge keep the register FULL
      state      <= FULL;
      rsp_data_q <= result;
      rsp_id_q   <= gnt1;
      ptr        <= ~gnt1;
      if (gnt0 && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
      if (gnt1 && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (state == FULL && bus.rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_valid  = (state == FULL);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign busy           = (state == FULL);

endmodule

// File: tb/tb_btr_share_arb.sv
// Bench for btr_share_arb: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbiter.
module tb_btr_share_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btr_share_if bus ();
  btr_share_if bus2 ();

  logic       busy, busy2;
  logic [7:0] gnt_cnt0, gnt_cnt1;
  logic [1:0] sat_cnt0, sat_cnt1;

  btr_share_arb #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  btr_share_arb #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .bus(bus2), .busy(busy2), .gnt_cnt0(sat_cnt0), .gnt_cnt1(sat_cnt1)
  );

  int errors = 0;
  int checks = 0;

  // model: register occupancy, content, turn, grant totals
  logic        m_full;
  logic [15:0] m_data;
  logic        m_id;
  logic        m_turn;
  int          m_cnt0, m_cnt1;
  int          m_last;

  function automatic logic [15:0] ref_rev(input logic [15:0] d, input logic op);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (!op) r[15-i] = d[i];
      else if (i < 8) r[7-i] = d[i];
      else r[23-i] = d[i];
    end
    return r;
  endfunction

  // -1 none, else the requester expected to be granted this cycle
  function automatic int exp_winner();
    if (m_full && !bus.rsp_ready) return -1;
    if (bus.req0_valid && bus.req1_valid) return m_turn ? 1 : 0;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [7:0] sat8(input int c);
    return (c > 255) ? 8'hFF : 8'(c);
  endfunction

  task automatic model_reset();
    m_full = 0; m_data = '0; m_id = 0; m_turn = 0; m_cnt0 = 0; m_cnt1 = 0; m_last = -1;
  endtask

  task automatic tick();
    int w;
    w = exp_winner();
    @(posedge clk);
    #1;
    m_last = w;
    if (w == 0) begin
      m_full = 1; m_id = 0; m_turn = 1; m_cnt0++;
      m_data = ref_rev(bus.req0_data, bus.req0_op);
    end else if (w == 1) begin
      m_full = 1; m_id = 1; m_turn = 0; m_cnt1++;
      m_data = ref_rev(bus.req1_data, bus.req1_op);
    end else if (m_full && bus.rsp_ready) begin
      m_full = 0;
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_data = '0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_data = '0; bus.req1_op = 0;
    bus.rsp_ready = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    bus.req0_valid = 1; bus.req1_valid = 1; bus.rsp_ready = 1;
    model_reset();
    #1;
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'h0 || bus.rsp_id !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_rsp got v=%b d=%h id=%b busy=%b want 0 0000 0 0",
                         bus.rsp_valid, bus.rsp_data, bus.rsp_id, busy);
    end
    checks++;
    if (gnt_cnt0 !== 8'd0 || gnt_cnt1 !== 8'd0) begin
      errors++; $display("FAIL reset_cnt got %0d %0d want 0 0", gnt_cnt0, gnt_cnt1);
    end
    @(negedge clk);
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_single();
    apply_reset();
    bus.req0_valid = 1; bus.req0_data = 16'h0001; bus.req0_op = 0; bus.rsp_ready = 1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req0_valid = 0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h8000 || bus.rsp_id !== 1'b0) begin
      errors++; $display("FAIL single_rsp got v=%b d=%h id=%b want 1 8000 0",
                         bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    checks++;
    if (gnt_cnt0 !== 8'd1 || gnt_cnt1 !== 8'd0) begin
      errors++; $display("FAIL single_cnt got %0d %0d want 1 0", gnt_cnt0, gnt_cnt1);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_drain got v=%b busy=%b want 0 0", bus.rsp_valid, busy);
    end
  endtask

  task automatic test_byte_mode();
    bus.req1_valid = 1; bus.req1_data = 16'h0180; bus.req1_op = 1; bus.rsp_ready = 1;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      errors++; $display("FAIL byte_ready got %b%b want 01", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req1_valid = 0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h8001 || bus.rsp_id !== 1'b1) begin
      errors++; $display("FAIL byte_rsp got v=%b d=%h id=%b want 1 8001 1",
                         bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [15:0] exp_d;
    int want;
    apply_reset();
    bus.rsp_ready = 1;
    for (int k = 0; k < 6; k++) begin
      bus.req0_valid = 1; bus.req0_data = 16'($urandom); bus.req0_op = 1'($urandom);
      bus.req1_valid = 1; bus.req1_data = 16'($urandom); bus.req1_op = 1'($urandom);
      want = k % 2;
      exp_d = (want == 0) ? ref_rev(bus.req0_data, bus.req0_op) : ref_rev(bus.req1_data, bus.req1_op);
      #1;
      checks++;
      if (bus.req0_ready !== (want == 0) || bus.req1_ready !== (want == 1)) begin
        errors++; $display("FAIL rr_order cycle %0d got %b%b want grant %0d",
                           k, bus.req0_ready, bus.req1_ready, want);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(want) || bus.rsp_data !== exp_d) begin
        errors++; $display("FAIL rr_rsp cycle %0d got v=%b id=%b d=%h want 1 %0d %h",
                           k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, want, exp_d);
      end
    end
    checks++;
    if (gnt_cnt0 !== 8'd3 || gnt_cnt1 !== 8'd3) begin
      errors++; $display("FAIL rr_cnt got %0d %0d want 3 3", gnt_cnt0, gnt_cnt1);
    end
    idle_inputs();
    bus.rsp_ready = 1;
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.req0_valid = 1; bus.req0_data = 16'hF000; bus.req0_op = 0; bus.rsp_ready = 1;
    tick();
    bus.req0_valid = 0; bus.rsp_ready = 0;
    bus.req1_valid = 1; bus.req1_data = 16'h1234; bus.req1_op = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (bus.req1_ready !== 1'b0 || bus.req0_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready cycle %0d got %b%b want 00", k, bus.req0_ready, bus.req1_ready);
      end
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h000F || bus.rsp_id !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b d=%h id=%b want 1 000f 0",
                           k, bus.rsp_valid, bus.rsp_data, bus.rsp_id);
      end
      tick();
    end
    bus.rsp_ready = 1;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got %b want 1", bus.req1_ready);
    end
    tick();
    bus.req1_valid = 0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== 16'h2C48) begin
      errors++; $display("FAIL bp_release_rsp got v=%b id=%b d=%h want 1 1 2c48",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.rsp_ready = 1;
    bus.req0_valid = 1; bus.req0_data = 16'h00FF; bus.req0_op = 0;
    tick();
    bus.req0_valid = 0; bus.rsp_ready = 0;
    #2;
    rst = 1;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.rsp_data !== 16'h0) begin
      errors++; $display("FAIL midrst_rsp got v=%b busy=%b d=%h want 0 0 0000",
                         bus.rsp_valid, busy, bus.rsp_data);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    checks++;
    if (gnt_cnt0 !== 8'd0 || gnt_cnt1 !== 8'd0) begin
      errors++; $display("FAIL midrst_cnt got %0d %0d want 0 0", gnt_cnt0, gnt_cnt1);
    end
    bus.req0_valid = 1; bus.req1_valid = 1; bus.rsp_ready = 1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_ptr got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    tick();
    idle_inputs();
    bus.rsp_ready = 1;
    tick();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c;
    bus2.req0_valid = 1; bus2.req0_data = 16'hA5A5; bus2.req0_op = 0; bus2.rsp_ready = 1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      exp_c = (k > 3) ? 2'b11 : 2'(k);
      checks++;
      if (sat_cnt0 !== exp_c || sat_cnt1 !== 2'b00) begin
        errors++; $display("FAIL sat_cnt grant %0d got %0d %0d want %0d 0", k, sat_cnt0, sat_cnt1, exp_c);
      end
    end
    bus2.req0_valid = 0;
  endtask

  task automatic test_random();
    int w;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      if (!(bus.req0_valid && m_last != 0 && !(k == 0))) begin
        bus.req0_valid = ($urandom_range(0, 99) < 60);
        bus.req0_data  = 16'($urandom);
        bus.req0_op    = 1'($urandom);
      end
      if (!(bus.req1_valid && m_last != 1 && !(k == 0))) begin
        bus.req1_valid = ($urandom_range(0, 99) < 60);
        bus.req1_data  = 16'($urandom);
        bus.req1_op    = 1'($urandom);
      end
      bus.rsp_ready = ($urandom_range(0, 99) < 70);
      #1;
      w = exp_winner();
      checks++;
      if (bus.req0_ready !== (w == 0) || bus.req1_ready !== (w == 1)) begin
        errors++; $display("FAIL rand_ready cycle %0d got %b%b want winner %0d",
                           k, bus.req0_ready, bus.req1_ready, w);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== m_full || busy !== m_full ||
          (m_full && (bus.rsp_data !== m_data || bus.rsp_id !== m_id))) begin
        errors++; $display("FAIL rand_rsp cycle %0d got v=%b d=%h id=%b want v=%b d=%h id=%b",
                           k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, m_full, m_data, m_id);
      end
      checks++;
      if (gnt_cnt0 !== sat8(m_cnt0) || gnt_cnt1 !== sat8(m_cnt1)) begin
        errors++; $display("FAIL rand_cnt cycle %0d got %0d %0d want %0d %0d",
                           k, gnt_cnt0, gnt_cnt1, sat8(m_cnt0), sat8(m_cnt1));
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    bus2.req0_valid = 0; bus2.req0_data = '0; bus2.req0_op = 0;
    bus2.req1_valid = 0; bus2.req1_data = '0; bus2.req1_op = 0;
    bus2.rsp_ready = 0;
    model_reset();
    test_reset();
    test_single();
    test_byte_mode();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btr_share_arb.md
Name: btr_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one bit-reverse datapath between two requesters, e.g. the execute stage and the debug/self-test path.
- Each request carries a 16-bit operand and an op select.
- The block grants one requester per cycle, computes the result combinationally, and holds it in an output register.
- The result is presented on a valid/ready response channel tagged with the requester ID.
- Per-requester 8-bit grant counters are exposed for performance checks.

Parameters:
- CNT_W, 8: width of each per-requester grant counter; counters saturate at all-ones.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a request.
- req0_data  input  16  requester 0 operand.
- req0_op  input  1  requester 0 op: 0 = full 16-bit reverse (bit i -> bit 15-i); 1 = reverse within each byte (bit i -> bit 7-i and bit 8+i -> bit 15-i).
- req0_ready  output  1  request 0 accepted this cycle.
- req1_valid  input  1  requester 1 has a request.
- req1_data  input  16  requester 1 operand.
- req1_op  input  1  requester 1 op; same encoding as req0_op.
- req1_ready  output  1  request 1 accepted this cycle.
- rsp_valid  output  1  rsp_data and rsp_id are valid.
- rsp_data  output  16  registered result.
- rsp_id  output  1  requester that owns the result.
- rsp_ready  input  1  consumer takes the response this cycle.
- busy  output  1  equals rsp_valid.
- gnt_cnt0  output  CNT_W  number of grants to requester 0, saturating.
- gnt_cnt1  output  CNT_W  number of grants to requester 1, saturating.

Behaviour:
- Reset (asynchronous, while rst=1):
  - State EMPTY; rsp_valid=0, rsp_data=0, rsp_id=0.
  - Priority pointer = requester 0.
  - Both grant counters = 0.
  - reqN_ready=0 while rst is high.
  - A reset mid-transaction discards any held response, with no further side effects.
- States:
  - EMPTY: output register holds nothing.
  - FULL: output register holds an unconsumed result.
- Accept condition: can_accept = (state==EMPTY) or (state==FULL and rsp_ready).
- Grant, combinational in the current cycle:
  - If only one valid is high, that requester wins.
  - If both are high, the requester named by the pointer wins.
  - reqN_ready = can_accept and (N wins). At most one ready is high in any cycle.
  - A ready never asserts without the matching valid.
- On an accepted request (reqN_valid and reqN_ready at the edge):
  - rsp_data <= op-transformed reqN_data; rsp_id <= N.
  - State -> FULL.
  - Pointer <= the other requester (1-N).
  - gnt_cntN increments unless it is already all-ones.
- Pointer movement: the pointer updates only on a grant. Idle cycles leave it unchanged.
- On a response handshake with no new accept (FULL, rsp_ready=1, no valid): state -> EMPTY; rsp_valid drops the next cycle.
- Simultaneous drain and accept (FULL, rsp_ready=1, a valid high):
  - The new result overwrites the register on the same edge.
  - State stays FULL and rsp_valid stays 1.
  - This gives full throughput of one result per cycle.
- Backpressure (FULL, rsp_ready=0):
  - Both readies are 0.
  - rsp_data and rsp_id are held stable.
  - Requesters must hold valid, data and op stable until ready.
- Latency: the response is visible exactly 1 cycle after the accept edge.
- Fairness: under continuous contention with rsp_ready=1, grants alternate 0,1,0,1 with no starvation.
- The datapath is purely combinational between the input mux and the output register. No arithmetic; width is always 16.

Test Plan:
- Reset, then req0_valid=1, data=16'h0001, op=0, rsp_ready=1 -> req0_ready=1 in that cycle; next cycle rsp_valid=1, rsp_data=16'h8000, rsp_id=0, gnt_cnt0=1.
- Byte mode: req1 data=16'h0180, op=1 -> rsp_data=16'h8001, rsp_id=1.
- Both valid every cycle with rsp_ready=1 for 6 cycles, pointer starting at 0 -> grant order 0,1,0,1,0,1; rsp_valid stays 1 throughout; gnt_cnt0=3, gnt_cnt1=3.
- Backpressure:
  - Accept req0 data=16'hF000, then hold rsp_ready=0 for 4 cycles with req1 valid -> req1_ready=0 for all 4; rsp_data=16'h000F held stable.
  - Raise rsp_ready -> req1 accepted on the same edge the response drains.
- Reset mid-transaction: assert rst asynchronously while FULL -> rsp_valid=0 immediately; after release, the pointer is at 0 and the counters are 0.
- Saturation (CNT_W=2): 5 grants to requester 0 -> gnt_cnt0 = 2'b11 with no wrap.
